// File: rtl/instr_prefetch_unit_pkg.sv
// Shared defaults for the instruction-fetch front end.
package riscp_pkg;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_PC_W    = 16;
    localparam int DEF_IMEM_AW = 11;
    // Wide all-ones pattern; users truncate it to their instruction width.
    localparam logic [63:0] NOP_INSTR = 64'hFFFF_FFFF_FFFF_FFFF;
endpackage

// File: rtl/instr_prefetch_unit_fetch_fifo.sv
// First-word-fall-through queue holding {pc, instruction} pairs.
// A flush empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pop of an empty queue is dropped; a push into a full queue only lands alongside a pop.
    always_comb begin
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end

    assign head_valid = (count_r != {CNT_W{1'b0}});
    assign head_data  = mem_r[rd_ptr_r];
    assign count      = count_r;
endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetcher: credit-based fetch issue, redirect handling and
// a small FWFT queue in front of decode.
module instr_prefetch_unit
    import riscp_pkg::*;
#(
    parameter int              INSTR_W  = DEF_INSTR_W,
    parameter int              PC_W     = DEF_PC_W,
    parameter int              IMEM_AW  = DEF_IMEM_AW,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     imem_rd_en,
    output logic [IMEM_AW-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr,
    output logic [PC_W-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]   queue_count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]     CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

    logic [PC_W-1:0]         fpc_r;
    logic [PC_W-1:0]         ret_pc_r;
    logic                    inflight_r;
    logic                    ret_oob_r;
    logic                    pop_s;
    logic                    push_s;
    logic                    issue_s;
    logic                    oob_s;
    logic                    head_valid_s;
    logic [CNT_W-1:0]        count_s;
    logic [CNT_W:0]          used_s;
    logic [INSTR_W-1:0]      ret_instr_s;
    logic [PC_W+INSTR_W-1:0] push_data_s;
    logic [PC_W+INSTR_W-1:0] head_data_s;

    // Issue only when queued entries plus the pending return still leave a free slot.
    always_comb begin
        pop_s  = instr_valid && instr_ready;
        used_s = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
        oob_s  = (fpc_r[PC_W-1:IMEM_AW] != {(PC_W - IMEM_AW){1'b0}});
        issue_s    = !reset && !redirect_valid && (used_s < CREDIT_LIMIT);
        imem_rd_en = issue_s && !oob_s;
        if (imem_rd_en) begin
            imem_addr = fpc_r[IMEM_AW-1:0];
        end else begin
            imem_addr = {IMEM_AW{1'b0}};
        end
        if (ret_oob_r) begin
            ret_instr_s = NOP;
        end else begin
            ret_instr_s = imem_rdata;
        end
        push_s      = inflight_r && !redirect_valid;
        push_data_s = {ret_pc_r, ret_instr_s};
    end

    // Decode-facing view of the queue head; reads as empty while reset is held.
    always_comb begin
        if (reset || !head_valid_s) begin
            instr_valid = 1'b0;
            instr       = {INSTR_W{1'b0}};
            instr_pc    = {PC_W{1'b0}};
        end else begin
            instr_valid = 1'b1;
            instr       = head_data_s[INSTR_W-1:0];
            instr_pc    = head_data_s[PC_W+INSTR_W-1:INSTR_W];
        end
        if (reset) begin
            queue_count = {CNT_W{1'b0}};
        end else begin
            queue_count = count_s;
        end
    end

    // Fetch PC and the one-deep record of the fetch awaiting its memory return.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_r      <= RESET_PC;
            inflight_r <= 1'b0;
            ret_pc_r   <= {PC_W{1'b0}};
            ret_oob_r  <= 1'b0;
        end else if (redirect_valid) begin
            fpc_r      <= redirect_pc;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                fpc_r     <= fpc_r + PC_W'(1'b1);
                ret_pc_r  <= fpc_r;
                ret_oob_r <= oob_s;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (PC_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_data  (push_data_s),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s),
        .count      (count_s)
    );
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench: the model predicts the in-order {pc, instr} stream that
// follows each reset or redirect; a monitor checks every accepted instruction.
module tb_instr_prefetch_unit;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_rd_en;
    logic [10:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [2:0]  queue_count;

    logic [15:0] mem [2048];

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] next_pc;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    instr_prefetch_unit #(
        .INSTR_W (16),
        .PC_W    (16),
        .IMEM_AW (11),
        .DEPTH   (4),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .queue_count   (queue_count)
    );

    // External synchronous instruction memory.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    function automatic logic [15:0] ref_instr(input logic [15:0] pc);
        if (pc < 16'h0800) return mem[pc[10:0]];
        return 16'hFFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc  = next_pc;
            e.ins = ref_instr(next_pc);
            exp_q.push_back(e);
            next_pc = next_pc + 16'd1;
        end
    endtask

    task automatic restart(input logic [15:0] base);
        exp_q.delete();
        next_pc = base;
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks accepted instructions, head stability and occupancy bound.
    initial begin : monitor
        exp_t        e;
        logic        hold;
        logic [15:0] h_ins;
        logic [15:0] h_pc;
        hold = 1'b0;
        h_ins = 16'h0;
        h_pc = 16'h0;
        forever begin
            @(negedge clk);
            chk("count_bound", 32'(queue_count <= 3'd4), 32'd1);
            if (hold && !reset) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_instr", 32'(instr), 32'(h_ins));
                chk("hold_pc", 32'(instr_pc), 32'(h_pc));
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got pc %0h expected no output", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", 32'(instr_pc), 32'(e.pc));
                    chk("out_instr", 32'(instr), 32'(e.ins));
                    refill();
                end
            end
            hold  = instr_valid && !instr_ready && !reset && !redirect_valid;
            h_ins = instr;
            h_pc  = instr_pc;
            if (reset) restart(RESET_PC);
            else if (redirect_valid) restart(redirect_pc);
        end
    end

    initial begin : stimulus
        logic found;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        instr_ready = 1'b1;
        imem_rdata = 16'h0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h8210;
        mem[1] = 16'h8420;
        mem[2] = 16'h0249;
        mem[3] = 16'hC0C0;
        mem[11'h7FE] = 16'h5A5A;
        mem[11'h7FF] = 16'hA5A5;

        repeat (3) step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);

        // Startup latency and streaming throughput.
        reset = 1'b0;
        #1;
        chk("boot_rd_en", 32'(imem_rd_en), 32'd1);
        chk("boot_addr", 32'(imem_addr), 32'(RESET_PC));
        chk("boot_c0_valid", 32'(instr_valid), 32'd0);
        step();
        chk("boot_c1_valid", 32'(instr_valid), 32'd0);
        step();
        chk("boot_c2_valid", 32'(instr_valid), 32'd1);
        chk("boot_c2_instr", 32'(instr), 32'h8210);
        chk("boot_c2_pc", 32'(instr_pc), 32'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("stream_valid", 32'(instr_valid), 32'd1);
        end

        // Back-pressure: queue saturates and fetching stops.
        step();
        reset = 1'b1;
        instr_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("stall_count", 32'(queue_count), 32'd4);
        chk("stall_rd_en", 32'(imem_rd_en), 32'd0);
        chk("stall_head_pc", 32'(instr_pc), 32'h0);
        chk("stall_head_instr", 32'(instr), 32'h8210);
        instr_ready = 1'b1;
        repeat (8) step();

        // Redirect with three queued and one in flight.
        reset = 1'b1;
        instr_ready = 1'b0;
        step();
        reset = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (queue_count == 3'd3) found = 1'b1;
        end
        chk("wait_q3", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_count", 32'(queue_count), 32'd0);
        chk("redir_rd_en", 32'(imem_rd_en), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'h010);
        instr_ready = 1'b1;
        repeat (6) step();

        // Redirect that runs off the end of instruction memory.
        redirect_valid = 1'b1;
        redirect_pc = 16'h07FE;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("edge_addr0", 32'(imem_addr), 32'h7FE);
        step();
        chk("edge_addr1", 32'(imem_addr), 32'h7FF);
        step();
        chk("edge_oob_rd_en", 32'(imem_rd_en), 32'd0);
        repeat (6) step();

        // Two consecutive redirects: the second wins.
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect_pc = 16'h0040;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("dbl_rd_en", 32'(imem_rd_en), 32'd1);
        chk("dbl_addr", 32'(imem_addr), 32'h040);
        repeat (6) step();

        // Reset pulse with a full queue.
        instr_ready = 1'b0;
        repeat (8) step();
        chk("full_count", 32'(queue_count), 32'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("pulse_valid", 32'(instr_valid), 32'd0);
        chk("pulse_count", 32'(queue_count), 32'd0);
        chk("pulse_rd_en", 32'(imem_rd_en), 32'd1);
        chk("pulse_addr", 32'(imem_addr), 32'(RESET_PC));
        instr_ready = 1'b1;
        repeat (6) step();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            step();
            reset = ($urandom_range(0, 99) < 2);
            redirect_valid = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 16'($urandom_range(0, 15));
                1:       redirect_pc = 16'($urandom_range(16'h07F0, 16'h0810));
                2:       redirect_pc = 16'hFFFE;
                default: redirect_pc = 16'($urandom_range(0, 16'h0FFF));
            endcase
            instr_ready = ($urandom_range(0, 9) < 7);
        end
        step();
        reset = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_unit.md
INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- INSTR_W, 16, instruction width in bits.
- PC_W, 16, program-counter width in bits.
- IMEM_AW, 11, instruction-memory word-address width; legal PC range is 0 .. 2^IMEM_AW-1.
- DEPTH, 4, prefetch queue entries (power of two, >= 2).
- RESET_PC, 0, fetch address after reset.
REQ-002 Ports (name  direction  width  meaning), one per line:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  PC_W  new fetch target.
- imem_rd_en  out  1  instruction-memory read strobe.
- imem_addr  out  IMEM_AW  read word address.
- imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_rd_en.
- instr_valid  out  1  queue head holds an instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr  out  INSTR_W  head instruction.
- instr_pc  out  PC_W  PC of head instruction.
- queue_count  out  $clog2(DEPTH)+1  occupied entries.
REQ-003 One clock (clk); reset is synchronous and active-high (reset); no other clock or reset.

Function
REQ-004 Fetch PC register fpc; a fetch issues in a cycle iff no reset, no redirect_valid, and queue_count + inflight + (pop ? -1 : 0) < DEPTH, where inflight is 1 if a fetch issued last cycle and was not squashed.
REQ-005 An issued in-range fetch drives imem_rd_en=1, imem_addr=fpc[IMEM_AW-1:0]; fpc advances by 1, modulo 2^PC_W.
REQ-006 Out-of-range fetch (fpc[PC_W-1:IMEM_AW] != 0): imem_rd_en=0; the slot is still consumed; NOP (all ones) is pushed with the same 1-cycle latency, tagged with that PC.
REQ-007 Return cycle: imem_rdata (or NOP) is pushed together with the PC of the issuing fetch; fetch-to-instr_valid latency is 2 cycles when the queue is empty.
REQ-008 Queue is first-word-fall-through; instr and instr_pc reflect the head whenever instr_valid=1.
REQ-009 Handshake: pop iff instr_valid && instr_ready; while instr_valid && !instr_ready, instr and instr_pc hold stable.
REQ-010 Push and pop in the same cycle leave queue_count unchanged; the credit rule makes overflow impossible, and an underflow pop is ignored.
REQ-011 redirect_valid=1 (highest priority): the queue empties next cycle, any in-flight return is discarded, fpc <= redirect_pc, no fetch that cycle; instr_valid=0 the following cycle; a handshake in the redirect cycle still completes for the current head.
REQ-012 Back-to-back redirects: only the last one takes effect; the first fetch from redirect_pc issues the cycle after the final redirect.
REQ-013 Steady state with instr_ready=1 sustains one instruction per cycle.

Reset
REQ-014 While reset=1: fpc=RESET_PC, queue empty, inflight=0, imem_rd_en=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, queue_count=0.
REQ-015 Reset asserted mid-operation discards all queued and in-flight data; the first fetch issues at RESET_PC in the first cycle after reset deasserts.

Structure
REQ-016 Shared package riscp_pkg holds INSTR_W, PC_W, IMEM_AW defaults and the NOP_INSTR constant (all ones).
REQ-017 The queue is one sub-module, fetch_fifo (parametrised width and DEPTH, with a synchronous flush input); the PC/credit/redirect control stays in instr_prefetch_unit.
REQ-018 The instruction memory is external; this block contains no storage array other than fetch_fifo.

Verification
REQ-019 Reset released, instr_ready=1, memory[0..3]=8210,8420,0249,C0C0: instr 8210@pc0 valid 2 cycles after reset release, then one instruction per cycle in order.
REQ-020 instr_ready=0 for 10 cycles: queue_count saturates at 4, imem_rd_en=0 once full, head 8210@pc0 held stable; release yields pcs 0,1,2,3,4 with no loss or duplicate.
REQ-021 redirect_valid with redirect_pc=0x0010 while queue holds 3 entries and 1 in flight: instr_valid=0 next cycle, imem_addr=0x010 issued the cycle after, first output has instr_pc=0x0010.
REQ-022 redirect_pc=0x07FE with memory[7FE,7FF] programmed: outputs pc 0x07FE, 0x07FF, then 0x0800 with instr=FFFF and imem_rd_en=0 for that fetch.
REQ-023 Redirects on two consecutive cycles (0x0020 then 0x0040): no instruction from 0x0020 is ever presented; the first output has instr_pc=0x0040.
REQ-024 reset pulsed for 1 cycle while the queue is full: instr_valid=0 and queue_count=0 the following cycle; the next fetch is at RESET_PC.
